// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, round constant seed, S-box, xtime and SubWord.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [3:0] LAST_RND  = 4'd10;

  // Forward S-box, entry x is the byte at bits [8x +: 8].
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{x, 3'b000} +: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_round_core.sv
// One combinational AES round: SubBytes, ShiftRows and MixColumns (skipped when mix is low).
module aes_round_core
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic         mix,
  output logic [127:0] out
);

  logic [127:0] shifted;

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // State byte 4*c+r sits at bits [127-8*(4*c+r) -: 8]; row r rotates left by r columns.
  // NOTE: every signal driven in this block gets a full default first, so no latch can be inferred.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = sbox(st[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    out = shifted;
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        out[127-32*c -: 32] = mix_col(shifted[127-32*c -: 32]);
      end
    end
  end

endmodule

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: one shared round per cycle, keys expanded on the fly.
// Optional AES_BLK_CNT_EN adds the blk_cnt completed-block counter port.
module aes128_iter_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] plaintext,
  input  logic [0:127] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] en_msg
`ifdef AES_BLK_CNT_EN
  ,
  output logic [31:0]  blk_cnt
`endif
);

  state_e       state;
  logic [127:0] st;
  logic [127:0] rk;
  logic [127:0] rk_n;
  logic [127:0] round_out;
  logic [3:0]   rnd;
  logic [7:0]   rcon;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;

  // Next round key from the current one; word 0 is the leftmost 32 bits.
  always_comb begin
    w0_n = rk[127:96] ^ sub_word({rk[23:0], rk[31:24]}) ^ {rcon, 24'h0};
    w1_n = rk[95:64] ^ w0_n;
    w2_n = rk[63:32] ^ w1_n;
    w3_n = rk[31:0]  ^ w2_n;
    rk_n = {w0_n, w1_n, w2_n, w3_n};
  end

  aes_round_core u_round (
    .st  (st),
    .mix (rnd != LAST_RND),
    .out (round_out)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      en_msg    <= '0;
      st        <= '0;
      rk        <= '0;
      rnd       <= '0;
      rcon      <= RCON_INIT;
`ifdef AES_BLK_CNT_EN
      blk_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            st       <= plaintext ^ key;
            rk       <= key;
            rnd      <= 4'd1;
            rcon     <= RCON_INIT;
            in_ready <= 1'b0;
            state    <= ROUND;
          end
        end
        ROUND: begin
          st   <= round_out ^ rk_n;
          rk   <= rk_n;
          rcon <= xtime(rcon);
          rnd  <= rnd + 4'd1;
          if (rnd == LAST_RND) begin
            en_msg    <= round_out ^ rk_n;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // en_msg is left untouched here so it keeps the last ciphertext.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
`ifdef AES_BLK_CNT_EN
            blk_cnt   <= blk_cnt + 32'd1;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/aes128_iter_ctrl.md
# aes128_iter_ctrl

Iterative AES-128 encryption controller. It sequences a single shared round datapath through the initial AddRoundKey and ten rounds, and expands the round keys on the fly, one per cycle. It replaces the fully unrolled ten-round combinational encryptor wherever area matters more than throughput. Blocks enter and leave through valid/ready handshakes.

## Interface
Parameters: none. The block is fixed to AES-128.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  plaintext and key are valid.
- in_ready  output  1  controller can accept a block.
- plaintext  input  [0:127]  input block; bit 0 is the MSB of byte 0 (FIPS-197 order).
- key  input  [0:127]  cipher key, same bit order.
- out_valid  output  1  en_msg holds a finished ciphertext.
- out_ready  input  1  downstream accepts en_msg.
- en_msg  output  [0:127]  ciphertext.
- blk_cnt  output  [31:0]  number of completed blocks; present only with AES_BLK_CNT_EN.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- FSM states: IDLE, ROUND, DONE.
- Reset values:
  - state = IDLE; in_ready = 1; out_valid = 0.
  - en_msg = 0; round counter = 0; rcon = 8'h01; blk_cnt = 0.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: st <= plaintext ^ key; rk <= key; rnd <= 1; rcon <= 8'h01; go to ROUND.
- ROUND, each cycle:
  - rk_n = next key word set. w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon, 24'h0}; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - st <= round(st, mix = (rnd != 10)) ^ rk_n; rk <= rk_n.
  - rcon <= xtime(rcon), giving the sequence 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - rnd <= rnd + 1.
  - When rnd == 10: capture the result into en_msg and go to DONE.
- round() applies SubBytes, then ShiftRows, then MixColumns. MixColumns is bypassed in round 10.
- DONE:
  - out_valid = 1; en_msg is held stable.
  - On out_ready: go to IDLE and clear out_valid. en_msg keeps its last value.
- in_ready is 0 in ROUND and DONE. plaintext and key are sampled only on the accept edge; changes after that are ignored.
- If in_valid drops while the controller is in IDLE, nothing happens; there is no pending state.
- GF(2^8) arithmetic uses the polynomial 0x11b. All XORs are full width, with no carries.

## Timing
- Accept edge is E0. Rounds 1–10 complete at edges E1–E10. out_valid rises after E10, so latency is 10 cycles from accept to out_valid.
- If out_ready is already high, DONE lasts one cycle and in_ready reasserts after E11.
- Maximum throughput is one block per 12 cycles: 1 IDLE + 10 ROUND + 1 DONE.
- There is no same-cycle turnaround: in_ready is low during the cycle in which out_valid and out_ready handshake.
- out_valid must not drop without out_ready. Output stalls of any length are allowed.
- rst_n asserted mid-operation aborts the block immediately. No partial output is produced, and the block returns to reset values.

## Configuration
- AES_BLK_CNT_EN:
  - Defined: the blk_cnt port exists. It increments by 1 on each out_valid && out_ready, wraps from 32'hFFFFFFFF to 0, and resets to 0.
  - Undefined: the port and its counter are absent; all other behaviour is identical.

## Structure
- aes_pkg holds:
  - the S-box function;
  - xtime;
  - the RCON_INIT constant (8'h01);
  - the FSM state enum;
  - the SubWord function used by the key step.
- Sub-module aes_round_core: one combinational round (SubBytes, ShiftRows, optional MixColumns via a mix input). It is instantiated exactly once. The key step stays in the controller.

## Test plan
- FIPS-197 Appendix C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> en_msg 69c4e0d86a7b0430d8cdb78070b4c55a, 10 cycles after accept.
- FIPS-197 Appendix B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. Check intermediate rk after E10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key and plaintext -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Back-pressure: hold out_ready low 20 cycles -> out_valid stays 1, en_msg is stable, in_ready stays 0; release -> handshake, then in_ready = 1 next cycle.
- Input changes during ROUND: change plaintext and key each cycle after accept -> result still equals the Appendix B ciphertext.
- Reset: pulse rst_n low at E5 -> out_valid = 0, en_msg = 0, in_ready = 1 asynchronously. With AES_BLK_CNT_EN, three completed blocks -> blk_cnt = 3, then 0 after reset.
